// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, sub-op selects, flag bit positions
// and conditional-branch test selects.
package alu_pkg;

    localparam int unsigned FLAG_W = 4;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_ROT   = 4'b0110;
    localparam logic [3:0] OP_UNARY = 4'b1000;

    localparam logic [1:0] RA_RLC  = 2'b00;
    localparam logic [1:0] RA_RRC  = 2'b01;
    localparam logic [1:0] RA_SETC = 2'b10;
    localparam logic [1:0] RA_CLRC = 2'b11;

    localparam logic [1:0] RA_NOT = 2'b00;
    localparam logic [1:0] RA_NEG = 2'b01;
    localparam logic [1:0] RA_INC = 2'b10;
    localparam logic [1:0] RA_DEC = 2'b11;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    localparam logic [1:0] BR_Z = 2'b00;
    localparam logic [1:0] BR_N = 2'b01;
    localparam logic [1:0] BR_C = 2'b10;
    localparam logic [1:0] BR_V = 2'b11;

    localparam logic [3:0] M_NONE = 4'b0000;
    localparam logic [3:0] M_ALL  = 4'b1111;
    localparam logic [3:0] M_ZN   = 4'b0110;
    localparam logic [3:0] M_ZNV  = 4'b1110;
    localparam logic [3:0] M_C    = 4'b0001;

    // One-hot flag position tested by a branch select.
    function automatic logic [3:0] br_onehot(input logic [1:0] cond);
        logic [3:0] oh;
        oh = 4'b0000;
        case (cond)
            BR_Z:    oh[FLAG_Z] = 1'b1;
            BR_N:    oh[FLAG_N] = 1'b1;
            BR_C:    oh[FLAG_C] = 1'b1;
            default: oh[FLAG_V] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ccr_mask_dec.sv
// Opcode/sub-op to flag write mask, plus carry force-set/force-clear
// for SETC and CLRC.
module ccr_mask_dec
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [1:0] ra_i,
    output logic [3:0] wmask_o,
    output logic       set_c_o,
    output logic       clr_c_o
);

    always_comb begin
        wmask_o = M_NONE;
        set_c_o = 1'b0;
        clr_c_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB: wmask_o = M_ALL;
            OP_AND, OP_OR:  wmask_o = M_ZN;
            OP_ROT: begin
                wmask_o = M_C;
                set_c_o = (ra_i == RA_SETC);
                clr_c_o = (ra_i == RA_CLRC);
            end
            OP_UNARY: begin
                case (ra_i)
                    RA_NOT:  wmask_o = M_ZN;
                    RA_NEG:  wmask_o = M_ZNV;
                    default: wmask_o = M_ALL;
                endcase
            end
            default: wmask_o = M_NONE;
        endcase
    end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register behind the ALU: masked flag capture, branch
// test with flag clear, and a single-level interrupt shadow.
module ccr_unit
    import alu_pkg::*;
#(
    parameter int unsigned FLAGS     = FLAG_W,
    parameter logic [3:0]  RESET_CCR = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [3:0]       alu_opcode,
    input  logic [1:0]       alu_ra,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             stall,
    input  logic             int_save,
    input  logic             rti_restore,
    input  logic             br_check,
    input  logic [1:0]       br_cond,
    output logic [FLAGS-1:0] ccr_out,
    output logic             c_out,
    output logic             br_taken,
    output logic             shadow_valid,
    output logic             ccr_err
);

    logic [FLAGS-1:0] ccr_q, ccr_d;
    logic [FLAGS-1:0] shadow_q;
    logic             sv_q;
    logic             err_q;

    logic [3:0] wmask;
    logic       set_c;
    logic       clr_c;
    logic [3:0] alu_flags;
    logic [3:0] wr_mask;
    logic [3:0] br_oh;
    logic [3:0] clr_mask;
    logic       save_ok;
    logic       rest_ok;
    logic       err_d;

    ccr_mask_dec u_dec (
        .opcode_i (alu_opcode),
        .ra_i     (alu_ra),
        .wmask_o  (wmask),
        .set_c_o  (set_c),
        .clr_c_o  (clr_c)
    );

    assign br_oh    = br_onehot(br_cond);
    assign br_taken = br_check & |(ccr_q & br_oh);
    assign clr_mask = br_taken ? br_oh : 4'b0000;
    assign wr_mask  = alu_valid ? wmask : 4'b0000;

    always_comb begin
        alu_flags = {alu_v, alu_n, alu_z, alu_c};
        if (set_c) alu_flags[FLAG_C] = 1'b1;
        if (clr_c) alu_flags[FLAG_C] = 1'b0;
    end

    // ALU write beats the branch clear on the same flag.
    assign ccr_d = (wr_mask & alu_flags) | (~wr_mask & ccr_q & ~clr_mask);

    assign save_ok = int_save & ~rti_restore & ~sv_q;
    assign rest_ok = rti_restore & ~int_save & sv_q;
    assign err_d   = (int_save & rti_restore)
                   | (int_save & ~rti_restore & sv_q)
                   | (rti_restore & ~int_save & ~sv_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q    <= RESET_CCR;
            shadow_q <= '0;
            sv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else if (stall) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (rest_ok) begin
                ccr_q <= shadow_q;
                sv_q  <= 1'b0;
            end else begin
                ccr_q <= ccr_d;
            end
            if (save_ok) begin
                shadow_q <= ccr_d;
                sv_q     <= 1'b1;
            end
        end
    end

    assign ccr_out      = ccr_q;
    assign c_out        = ccr_q[FLAG_C];
    assign shadow_valid = sv_q;
    assign ccr_err      = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit with a queue-based expected-result
// scoreboard.
module tb_ccr_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, alu_valid, stall, int_save, rti_restore, br_check;
    logic [3:0] alu_opcode;
    logic [1:0] alu_ra, br_cond;
    logic       alu_c, alu_z, alu_n, alu_v;
    logic [3:0] ccr_out;
    logic       c_out, br_taken, shadow_valid, ccr_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] ccr;
        logic       sv;
        logic       err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ccr_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_opcode   (alu_opcode),
        .alu_ra       (alu_ra),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_n        (alu_n),
        .alu_v        (alu_v),
        .stall        (stall),
        .int_save     (int_save),
        .rti_restore  (rti_restore),
        .br_check     (br_check),
        .br_cond      (br_cond),
        .ccr_out      (ccr_out),
        .c_out        (c_out),
        .br_taken     (br_taken),
        .shadow_valid (shadow_valid),
        .ccr_err      (ccr_err)
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; alu_valid = 0; alu_opcode = 4'b0000; alu_ra = 2'b00;
        {alu_v, alu_n, alu_z, alu_c} = 4'b0000;
        stall = 0; int_save = 0; rti_restore = 0;
        br_check = 0; br_cond = 2'b00;
    endtask

    // Drive one cycle of stimulus, push expectations, clock, then pop
    // and compare registered results.
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [1:0] ra, input logic [3:0] vnzc,
                        input logic val, input logic bchk,
                        input logic [1:0] bcond, input logic bt_exp,
                        input logic [3:0] ccr_exp, input logic sv_exp,
                        input logic err_exp);
        exp_t e;
        alu_valid = val; alu_opcode = op; alu_ra = ra;
        {alu_v, alu_n, alu_z, alu_c} = vnzc;
        br_check = bchk; br_cond = bcond;
        e.tag = tag; e.ccr = ccr_exp; e.sv = sv_exp; e.err = err_exp;
        sb.push_back(e);
        #1;
        if (bchk || bt_exp) chk({tag, "_bt"}, {3'b0, br_taken}, {3'b0, bt_exp});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ccr"}, ccr_out, e.ccr);
            chk({e.tag, "_cout"}, {3'b0, c_out}, {3'b0, e.ccr[FLAG_C]});
            chk({e.tag, "_sv"}, {3'b0, shadow_valid}, {3'b0, e.sv});
            chk({e.tag, "_err"}, {3'b0, ccr_err}, {3'b0, e.err});
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        step("reset", 4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b0000, 0, 0);

        step("add",   OP_ADD, 2'b00, 4'b1011, 1, 0, 2'b00, 0, 4'b1011, 0, 0);
        step("and",   OP_AND, 2'b00, 4'b0100, 1, 0, 2'b00, 0, 4'b1101, 0, 0);
        step("clrc",  OP_ROT, RA_CLRC, 4'b0001, 1, 0, 2'b00, 0, 4'b1100, 0, 0);
        step("setc",  OP_ROT, RA_SETC, 4'b0000, 1, 0, 2'b00, 0, 4'b1101, 0, 0);
        step("rlc",   OP_ROT, RA_RLC, 4'b0010, 1, 0, 2'b00, 0, 4'b1100, 0, 0);
        step("noval", OP_ADD, 2'b00, 4'b1111, 0, 0, 2'b00, 0, 4'b1100, 0, 0);
        step("unlst", 4'b0000, 2'b00, 4'b1111, 1, 0, 2'b00, 0, 4'b1100, 0, 0);

        step("setz",  OP_ADD, 2'b00, 4'b0010, 1, 0, 2'b00, 0, 4'b0010, 0, 0);
        step("brz",   4'b0000, 2'b00, 4'b0000, 0, 1, BR_Z, 1, 4'b0000, 0, 0);
        step("setz2", OP_ADD, 2'b00, 4'b0010, 1, 0, 2'b00, 0, 4'b0010, 0, 0);
        step("brzal", OP_ADD, 2'b00, 4'b0011, 1, 1, BR_Z, 1, 4'b0011, 0, 0);
        step("brvnt", 4'b0000, 2'b00, 4'b0000, 0, 1, BR_V, 0, 4'b0011, 0, 0);
        step("brc",   4'b0000, 2'b00, 4'b0000, 0, 1, BR_C, 1, 4'b0010, 0, 0);

        step("add2",  OP_ADD, 2'b00, 4'b0101, 1, 0, 2'b00, 0, 4'b0101, 0, 0);
        step("neg",   OP_UNARY, RA_NEG, 4'b1010, 1, 0, 2'b00, 0, 4'b1011, 0, 0);
        int_save = 1;
        step("save",  OP_ADD, 2'b00, 4'b0101, 1, 0, 2'b00, 0, 4'b0101, 1, 0);
        step("add3",  OP_ADD, 2'b00, 4'b1010, 1, 0, 2'b00, 0, 4'b1010, 1, 0);
        int_save = 1;
        step("save2", 4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b1010, 1, 1);
        int_save = 1; rti_restore = 1;
        step("both",  4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b1010, 1, 1);
        rti_restore = 1;
        step("rti",   OP_ADD, 2'b00, 4'b1111, 1, 0, 2'b00, 0, 4'b0101, 0, 0);
        rti_restore = 1;
        step("rti2",  4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b0101, 0, 1);
        step("idle",  4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b0101, 0, 0);

        stall = 1; int_save = 1;
        step("stall", OP_ADD, 2'b00, 4'b0000, 1, 1, BR_C, 1, 4'b0101, 0, 0);
        int_save = 1;
        step("save3", 4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b0101, 1, 0);
        rst = 1;
        step("rstint", OP_ADD, 2'b00, 4'b1111, 1, 0, 2'b00, 0, 4'b0000, 0, 0);
        rti_restore = 1;
        step("rti3",  4'b0000, 2'b00, 4'b0000, 0, 0, 2'b00, 0, 4'b0000, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
